// File: rtl/pe_requant_if.sv
// BRAM port plus start/done handshake shared between pe_requant and its host.
// master = the requantizer side, slave = the BRAM / controller side.
interface pe_requant_if #(
   parameter int BRAM_ADDR_WIDTH = 15,
   parameter int BRAM_DATA_WIDTH = 32,
   parameter int BRAM_WE_WIDTH   = 4
);
   logic                       start;
   logic                       done;
   logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
   logic [BRAM_DATA_WIDTH-1:0] bram_rddata;
   logic [BRAM_DATA_WIDTH-1:0] bram_wrdata;
   logic [BRAM_WE_WIDTH-1:0]   bram_we;

   modport master (
      input  start,
      input  bram_rddata,
      output done,
      output bram_addr,
      output bram_wrdata,
      output bram_we
   );

   modport slave (
      output start,
      output bram_rddata,
      input  done,
      input  bram_addr,
      input  bram_wrdata,
      input  bram_we
   );
endinterface

// File: rtl/pe_requant.sv
// Reads 64 int32 accumulators from BRAM, requantizes each to int8 (multiply,
// rounding shift, zero point, clamp) and writes them back packed 4 per word.
module pe_requant #(
   parameter int RESULT_WIDTH     = 32,
   parameter int BRAM_ADDR_WIDTH  = 15,
   parameter int BRAM_DATA_WIDTH  = 32,
   parameter int BRAM_WE_WIDTH    = 4,
   parameter int LINE_SIZE        = 8,
   parameter int SRC_BASE         = 0,
   parameter int PARAM_ADDR       = 256,
   parameter int DST_BASE         = 512,
   parameter int DONE_STATE_CYCLE = 5
) (
   input  logic          i_clk,
   input  logic          i_reset,
   pe_requant_if.master  bus
);

   localparam int N_ELEM = LINE_SIZE * LINE_SIZE;
   localparam int N_GRP  = N_ELEM / 4;
   localparam int G_W    = (N_GRP > 1) ? $clog2(N_GRP) : 1;
   localparam int D_W    = $clog2(DONE_STATE_CYCLE + 1);
   localparam int AW     = BRAM_ADDR_WIDTH;
   localparam int PW     = RESULT_WIDTH + 17;
   localparam int RW     = PW + 1;
   localparam int YW     = PW + 2;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PWAIT = 3'd1;
   localparam logic [2:0] S_PCAP  = 3'd2;
   localparam logic [2:0] S_RD    = 3'd3;
   localparam logic [2:0] S_CAP   = 3'd4;
   localparam logic [2:0] S_WR    = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [AW-1:0]  A_SRC   = AW'(SRC_BASE);
   localparam logic [AW-1:0]  A_PARAM = AW'(PARAM_ADDR);
   localparam logic [AW-1:0]  A_DST   = AW'(DST_BASE);
   localparam logic [G_W-1:0] G_LAST  = G_W'(N_GRP - 1);
   localparam logic [D_W-1:0] D_LAST  = D_W'(DONE_STATE_CYCLE - 1);

   localparam logic signed [YW-1:0] Q_MAX = YW'(127);
   localparam logic signed [YW-1:0] Q_MIN = -YW'(128);

   // (p + 2^(s-1)) >>> s, widened by one bit so the rounding add cannot wrap
   function automatic logic signed [RW-1:0] round_shift(
      input logic signed [PW-1:0] p,
      input logic [4:0]           s
   );
      logic signed [RW-1:0] ext;
      logic signed [RW-1:0] rnd;
      ext = {p[PW-1], p};
      if (s == 5'd0) return ext;
      rnd = {{(RW-1){1'b0}}, 1'b1} << (s - 5'd1);
      return (ext + rnd) >>> s;
   endfunction

   function automatic logic [7:0] sat_i8(input logic signed [YW-1:0] y);
      if (y > Q_MAX) return 8'h7F;
      if (y < Q_MIN) return 8'h80;
      return y[7:0];
   endfunction

   function automatic logic [7:0] requant(
      input logic [RESULT_WIDTH-1:0] a,
      input logic [15:0]             m,
      input logic [4:0]              s,
      input logic [7:0]              z
   );
      logic signed [PW-1:0] a_ext;
      logic signed [PW-1:0] m_ext;
      logic signed [PW-1:0] p;
      logic signed [RW-1:0] r;
      logic signed [YW-1:0] y;
      a_ext = {{17{a[RESULT_WIDTH-1]}}, a};
      m_ext = {{(PW-16){1'b0}}, m};
      p     = a_ext * m_ext;
      r     = round_shift(p, s);
      y     = {r[RW-1], r} + {{(YW-8){z[7]}}, z};
      return sat_i8(y);
   endfunction

   logic [2:0]                 r_state;
   logic [G_W-1:0]             r_g;
   logic [1:0]                 r_k;
   logic [15:0]                r_m;
   logic [4:0]                 r_s;
   logic [7:0]                 r_z;
   logic [23:0]                r_pack;
   logic [D_W-1:0]             r_dcnt;
   logic [AW-1:0]              r_addr;
   logic [BRAM_DATA_WIDTH-1:0] r_wrdata;
   logic [BRAM_WE_WIDTH-1:0]   r_we;
   logic                       r_done;

   logic [1:0]     w_k_nxt;
   logic [G_W-1:0] w_g_nxt;
   logic [AW-1:0]  w_rd_addr_nxt;
   logic [AW-1:0]  w_grp_addr_nxt;
   logic [AW-1:0]  w_wr_addr;
   logic [7:0]     w_q;

   assign w_k_nxt        = r_k + 2'd1;
   assign w_g_nxt        = r_g + G_W'(1);
   assign w_rd_addr_nxt  = A_SRC + AW'({r_g, w_k_nxt, 2'b00});
   assign w_grp_addr_nxt = A_SRC + AW'({w_g_nxt, 4'b0000});
   assign w_wr_addr      = A_DST + AW'({r_g, 2'b00});
   assign w_q            = requant(bus.bram_rddata[RESULT_WIDTH-1:0], r_m, r_s, r_z);

   // Addresses are registered: the address for element k+1 is loaded while
   // the data for element k-1 arrives, giving the 4+1+1 cycle group cadence.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_g      <= '0;
         r_k      <= '0;
         r_m      <= '0;
         r_s      <= '0;
         r_z      <= '0;
         r_pack   <= '0;
         r_dcnt   <= '0;
         r_addr   <= '0;
         r_wrdata <= '0;
         r_we     <= '0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_we <= '0;
               if (bus.start) begin
                  r_addr  <= A_PARAM;
                  r_state <= S_PWAIT;
               end
            end
            S_PWAIT: r_state <= S_PCAP;
            S_PCAP: begin
               r_m     <= bus.bram_rddata[15:0];
               r_s     <= bus.bram_rddata[20:16];
               r_z     <= bus.bram_rddata[31:24];
               r_g     <= '0;
               r_k     <= '0;
               r_addr  <= A_SRC;
               r_state <= S_RD;
            end
            S_RD: begin
               r_k <= w_k_nxt;
               case (r_k)
                  2'd1:    r_pack[7:0]   <= w_q;
                  2'd2:    r_pack[15:8]  <= w_q;
                  2'd3:    r_pack[23:16] <= w_q;
                  default: ;
               endcase
               if (r_k == 2'd3) r_state <= S_CAP;
               else             r_addr  <= w_rd_addr_nxt;
            end
            S_CAP: begin
               r_wrdata <= BRAM_DATA_WIDTH'({w_q, r_pack});
               r_addr   <= w_wr_addr;
               r_we     <= '1;
               r_state  <= S_WR;
            end
            S_WR: begin
               r_we <= '0;
               if (r_g == G_LAST) begin
                  r_done  <= 1'b1;
                  r_dcnt  <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_g     <= w_g_nxt;
                  r_k     <= '0;
                  r_addr  <= w_grp_addr_nxt;
                  r_state <= S_RD;
               end
            end
            S_DONE: begin
               r_we <= '0;
               if (r_dcnt == D_LAST) begin
                  r_done  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_dcnt <= r_dcnt + D_W'(1);
               end
            end
            default: begin
               r_we    <= '0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.bram_addr   = r_addr;
   assign bus.bram_wrdata = r_wrdata;
   assign bus.bram_we     = r_we;
   assign bus.done        = r_done;

endmodule

// File: tb/tb_pe_requant.sv
// Bench for pe_requant: BRAM model, reference requantizer and a write scoreboard.
module tb_pe_requant;

   localparam int PARAM_ADDR = 256;
   localparam int DST_BASE   = 512;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;
   int   n_wr;
   int   acc [64];
   logic [31:0] mem [0:8191];
   logic [63:0] exp_q [$];

   pe_requant_if #(.BRAM_ADDR_WIDTH(15), .BRAM_DATA_WIDTH(32), .BRAM_WE_WIDTH(4)) bus ();

   pe_requant dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.bram_we == 4'hF) mem[bus.bram_addr[14:2]] <= bus.bram_wrdata;
      bus.bram_rddata <= mem[bus.bram_addr[14:2]];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: floor division instead of shifting, 64-bit throughout
   function automatic logic [7:0] ref_q(int a, int m, int s, int z);
      longint p, d, n, r, y;
      logic [63:0] yb;
      p = longint'(a) * longint'(m);
      if (s == 0) r = p;
      else begin
         d = longint'(1) << s;
         n = p + d / 2;
         r = n / d;
         if ((n % d != 0) && (n < 0)) r = r - 1;
      end
      y = r + longint'(z);
      if (y > 127)  return 8'h7F;
      if (y < -128) return 8'h80;
      yb = y;
      return yb[7:0];
   endfunction

   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && bus.bram_we != 4'h0) begin
         chk("we_full", {60'd0, bus.bram_we}, 64'hF);
         n_wr++;
         if (exp_q.size() == 0) chk("wr_unexpected", {49'd0, bus.bram_addr}, 64'hFFFF);
         else begin
            e = exp_q.pop_front();
            chk("wr_addr", {49'd0, bus.bram_addr}, {32'd0, e[63:32]});
            chk("wr_data", {32'd0, bus.bram_wrdata}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic load_pass(input logic [15:0] m, input logic [4:0] s, input logic signed [7:0] z);
      logic [31:0] w;
      mem[PARAM_ADDR/4] = {z, 3'b101, s, m};
      for (int e = 0; e < 64; e++) mem[e] = acc[e];
      for (int g = 0; g < 16; g++) mem[DST_BASE/4 + g] = 32'h0;
      for (int g = 0; g < 16; g++) begin
         for (int j = 0; j < 4; j++)
            w[8*j +: 8] = ref_q(acc[4*g+j], int'(m), int'(s), int'(z));
         exp_q.push_back({32'(DST_BASE + 4*g), w});
      end
      n_wr = 0;
   endtask

   task automatic rand_acc(input int lo);
      for (int e = lo; e < 64; e++) acc[e] = int'($urandom_range(0, 200000)) - 100000;
   endtask

   task automatic run_pass(input bit mid_start);
      int cyc;
      int hi;
      @(posedge clk); #1;
      bus.start = 1'b1;
      cyc = 0;
      while (cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) bus.start = 1'b0;
         if (mid_start && cyc == 40) bus.start = 1'b1;
         if (mid_start && cyc == 41) bus.start = 1'b0;
         if (bus.done) break;
      end
      chk("done_latency", 64'(cyc), 64'd99);
      hi = 1;
      while (bus.done && hi < 20) begin
         @(posedge clk); #1;
         if (bus.done) hi++;
      end
      chk("done_len", 64'(hi), 64'd5);
      repeat (12) @(posedge clk);
      #1;
      chk("write_count", 64'(n_wr), 64'd16);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int cyc;
      n_total = 0;
      n_bad   = 0;
      n_wr    = 0;
      bus.start = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we",   {60'd0, bus.bram_we}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_addr", {49'd0, bus.bram_addr}, 64'd0);
      rst = 1'b0;

      // identity, with an ignored start mid-pass
      rand_acc(8);
      acc[0] = 5; acc[1] = -7; acc[2] = 127; acc[3] = 128;
      acc[4] = -128; acc[5] = -129; acc[6] = 0; acc[7] = -1;
      load_pass(16'd1, 5'd0, 8'sd0);
      run_pass(1'b1);
      chk("ident_w0", {32'd0, mem[DST_BASE/4]},     64'h7F7FF905);
      chk("ident_w1", {32'd0, mem[DST_BASE/4 + 1]}, 64'hFF008080);

      // half-scale rounding
      rand_acc(4);
      acc[0] = 3; acc[1] = -3; acc[2] = 1; acc[3] = -1;
      load_pass(16'h4000, 5'd15, 8'sd0);
      run_pass(1'b0);
      chk("half_w0", {32'd0, mem[DST_BASE/4]}, 64'h0001FF02);

      // zero multiplier: every byte is the zero point
      rand_acc(0);
      load_pass(16'h0000, 5'd4, -8'sd10);
      run_pass(1'b0);
      for (int g = 0; g < 16; g++) chk("zp_word", {32'd0, mem[DST_BASE/4 + g]}, 64'hF6F6F6F6);

      // both saturation rails
      rand_acc(4);
      acc[0] = 32'h7FFFFFFF; acc[1] = 32'h80000000; acc[2] = 2; acc[3] = -2;
      load_pass(16'hFFFF, 5'd0, 8'sd0);
      run_pass(1'b0);
      chk("rail_w0", {32'd0, mem[DST_BASE/4]}, 64'h807F807F);

      // maximum shift
      rand_acc(1);
      acc[0] = 32'h7FFFFFFF;
      load_pass(16'hFFFF, 5'd31, 8'sd5);
      run_pass(1'b0);

      // reset during the write of group 7
      rand_acc(0);
      load_pass(16'h1234, 5'd10, -8'sd3);
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 0;
      while (cyc < 300 && !(bus.bram_we == 4'hF && bus.bram_addr == 15'(DST_BASE + 28))) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("abort_reached_wr7", 64'(cyc < 300), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_we",   {60'd0, bus.bram_we}, 64'd0);
      chk("abort_done", {63'd0, bus.done}, 64'd0);
      chk("abort_addr", {49'd0, bus.bram_addr}, 64'd0);
      chk("abort_wr_count", 64'(n_wr), 64'd7);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // fresh pass with new parameters after the abort
      rand_acc(0);
      load_pass(16'h0800, 5'd8, 8'sd7);
      run_pass(1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
